// File: rtl/mkio_pkg.sv
// Shared constants, state encoding and helpers for the MKIO Manchester-II receiver.
package mkio_pkg;

  // Clocks per Manchester half-bit element.
  localparam int HALF_BIT_CLKS = 8;
  // Each sync segment lasts three half-bits.
  localparam int SYNC_HALVES   = 3;
  // 16 data bits plus parity, two half-bits each.
  localparam int WORD_HALVES   = 34;
  // Allowed +/- clocks on the first sync segment.
  localparam int SYNC_TOL      = 4;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_A,
    SYNC_B,
    DATA,
    TAIL,
    WAIT_IDLE
  } rx_state_t;

  // Line pair encodings as {DI1, DI0}; 00 and 11 are both idle/invalid.
  localparam logic [1:0] LINE_HIGH = 2'b10;
  localparam logic [1:0] LINE_LOW  = 2'b01;
  localparam logic [1:0] LINE_IDLE = 2'b00;

  // Saturating increment for the sync run-length counter.
  function automatic logic [4:0] run_inc(input logic [4:0] r);
    return (r == 5'd31) ? r : r + 5'd1;
  endfunction

  // High when the 17 decoded bits (data + parity) do not have odd weight.
  function automatic logic parity_err(input logic [16:0] w);
    return ~^w;
  endfunction

endpackage

// File: rtl/mkio_line_sync.sv
// Two-flop synchronizer for the DI1/DI0 line pair plus active/level decode.
module mkio_line_sync
  import mkio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic di1_i,
  input  logic di0_i,
  output logic act_o,
  output logic lvl_o
);

  logic [1:0] meta_q;
  logic [1:0] sync_q;

  // Bring the asynchronous line pair into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= {di1_i, di0_i};
      sync_q <= meta_q;
    end
  end

  // Only the two differential states carry a level; lvl follows DI1 regardless.
  assign act_o = (sync_q == LINE_HIGH) || (sync_q == LINE_LOW);
  assign lvl_o = sync_q[1];

endmodule

// File: rtl/mkio_receiver.sv
// MKIO Manchester-II word receiver: sync detection, 17-bit decode, word strobe and error flags.
module mkio_receiver #(
  parameter int HALF_BIT_CLKS = mkio_pkg::HALF_BIT_CLKS,
  parameter int SYNC_TOL      = mkio_pkg::SYNC_TOL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DI1,
  input  logic        DI0,
  output logic        busy_rcv,
  output logic        imp_rcv,
  output logic        cd_rcv,
  output logic [15:0] data_rcv,
  output logic        err_manch,
  output logic        err_par
);

  import mkio_pkg::*;

  localparam int PH_W     = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam int SYNC_NOM = SYNC_HALVES * HALF_BIT_CLKS;

  localparam logic [4:0]      RUN_LO    = 5'(SYNC_NOM - SYNC_TOL);
  localparam logic [4:0]      RUN_HI    = 5'(SYNC_NOM + SYNC_TOL);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(HALF_BIT_CLKS - 1);
  localparam logic [PH_W-1:0] PH_MID    = PH_W'(HALF_BIT_CLKS / 2);
  localparam logic [PH_W-1:0] PH_STB    = PH_W'(HALF_BIT_CLKS / 2 + 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  // Second sync segment is checked at its centre, counted from the sync edge.
  localparam logic [5:0]      SB_HALF   = 6'((SYNC_NOM / 2) / HALF_BIT_CLKS);
  localparam logic [PH_W-1:0] SB_PH     = PH_W'((SYNC_NOM / 2) % HALF_BIT_CLKS);
  localparam logic [5:0]      SB_END    = 6'(SYNC_HALVES);
  localparam logic [5:0]      LAST_HALF = 6'(WORD_HALVES - 1);

  logic act;
  logic lvl;

  rx_state_t       state_q;
  logic [4:0]      run_q;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [5:0]      half_q, half_d;
  logic            sync_lvl_q;
  logic            first_lvl_q;
  logic            first_act_q;
  logic            manch_q;
  logic [16:0]     shift_q;
  logic            busy_q, imp_q, cd_q, em_q, ep_q;
  logic [15:0]     data_q;
  logic            bit_ok;
  logic            level_flip;

  mkio_line_sync u_line_sync (
    .clk   (clk),
    .rst_n (reset),
    .di1_i (DI1),
    .di0_i (DI0),
    .act_o (act),
    .lvl_o (lvl)
  );

  // Free-running half-bit timebase and per-bit Manchester validity.
  always_comb begin
    phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
    half_d     = (phase_q == PH_LAST) ? half_q + 6'd1 : half_q;
    bit_ok     = first_act_q && act && (first_lvl_q != lvl);
    level_flip = act && (lvl != sync_lvl_q);
  end

  // Receiver FSM; sync edge E resets the timebase so all samples fall on half-bit centres.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      run_q       <= '0;
      phase_q     <= '0;
      half_q      <= '0;
      sync_lvl_q  <= 1'b0;
      first_lvl_q <= 1'b0;
      first_act_q <= 1'b0;
      manch_q     <= 1'b0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      imp_q       <= 1'b0;
      cd_q        <= 1'b0;
      em_q        <= 1'b0;
      ep_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      imp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (act) begin
            sync_lvl_q <= lvl;
            run_q      <= 5'd1;
            state_q    <= SYNC_A;
          end
        end
        SYNC_A: begin
          if (!act) begin
            state_q <= WAIT_IDLE;
          end else if (level_flip) begin
            if (run_q >= RUN_LO && run_q <= RUN_HI) begin
              state_q <= SYNC_B;
              busy_q  <= 1'b1;
              phase_q <= PH_ONE;
              half_q  <= '0;
            end else begin
              state_q <= WAIT_IDLE;
            end
          end else if (run_q > RUN_HI) begin
            state_q <= WAIT_IDLE;
          end else begin
            run_q <= run_inc(run_q);
          end
        end
        SYNC_B: begin
          phase_q <= phase_d;
          half_q  <= half_d;
          if (half_q == SB_HALF && phase_q == SB_PH && !level_flip) begin
            state_q <= WAIT_IDLE;
            busy_q  <= 1'b0;
          end else if (half_q == SB_END && phase_q == '0) begin
            state_q <= DATA;
            half_q  <= '0;
            manch_q <= 1'b0;
          end
        end
        DATA: begin
          phase_q <= phase_d;
          half_q  <= half_d;
          if (phase_q == PH_MID) begin
            if (!half_q[0]) begin
              first_lvl_q <= lvl;
              first_act_q <= act;
            end else begin
              shift_q <= {shift_q[15:0], first_lvl_q};
              if (!bit_ok) manch_q <= 1'b1;
            end
            if (half_q == LAST_HALF) state_q <= TAIL;
          end
        end
        TAIL: begin
          phase_q <= phase_d;
          half_q  <= half_d;
          if (phase_q == PH_STB) begin
            imp_q  <= 1'b1;
            data_q <= shift_q[16:1];
            cd_q   <= ~sync_lvl_q;
            em_q   <= manch_q;
            ep_q   <= parity_err(shift_q);
          end else if (phase_q == '0) begin
            // Leaving TAIL doubles as the IDLE cycle so a back-to-back sync keeps its run count.
            busy_q <= 1'b0;
            if (act) begin
              sync_lvl_q <= lvl;
              run_q      <= 5'd1;
              state_q    <= SYNC_A;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (!act) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_rcv  = busy_q;
  assign imp_rcv   = imp_q;
  assign cd_rcv    = cd_q;
  assign data_rcv  = data_q;
  assign err_manch = em_q;
  assign err_par   = ep_q;

endmodule

// File: tb/tb_mkio_receiver.sv
// Directed bench for mkio_receiver: behavioural MKIO transmitter plus strobe scoreboard.
module tb_mkio_receiver;

  localparam int HB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        DI1, DI0;
  logic        busy_rcv, imp_rcv, cd_rcv, err_manch, err_par;
  logic [15:0] data_rcv;

  int cyc    = 0;
  int n_chk  = 0;
  int n_err  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mkio_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .DI1       (DI1),
    .DI0       (DI0),
    .busy_rcv  (busy_rcv),
    .imp_rcv   (imp_rcv),
    .cd_rcv    (cd_rcv),
    .data_rcv  (data_rcv),
    .err_manch (err_manch),
    .err_par   (err_par)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        cd;
    logic        em;
    logic        ep;
  } stb_t;

  stb_t sq[$];
  stb_t mon_s;

  always @(negedge clk) begin
    if (imp_rcv) begin
      mon_s.cyc  = cyc;
      mon_s.data = data_rcv;
      mon_s.cd   = cd_rcv;
      mon_s.em   = err_manch;
      mon_s.ep   = err_par;
      sq.push_back(mon_s);
    end
  end

  typedef struct {
    logic        cmd;
    logic [15:0] d;
    int          sync_len;
    logic        inv_par;
    int          force_bit;
    int          idle_after;
    int          gap;
    logic        exp_stb;
    int          lat;
    logic [15:0] exp_d;
    logic        exp_cd;
    logic        exp_em;
    logic        exp_ep;
  } vec_t;

  vec_t vecs[10];
  int   pv[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] pr, input int n);
    repeat (n) begin
      @(negedge clk);
      {DI1, DI0} = pr;
    end
  endtask

  // Emits one word; p is the first clock edge that sees an active line level.
  task automatic send_word(input logic cmd, input logic [15:0] d, input int sync_len,
                           input logic inv_par, input int force_bit, input int idle_after,
                           output int p);
    logic [16:0] bits;
    logic [1:0]  s1, s2, h1, h2;
    bits = {d, ~^d};
    if (inv_par) bits[0] = ~bits[0];
    s1 = cmd ? 2'b01 : 2'b10;
    s2 = cmd ? 2'b10 : 2'b01;
    @(negedge clk);
    p = cyc + 1;
    {DI1, DI0} = s1;
    drive(s1, sync_len - 1);
    drive(s2, 3 * HB);
    for (int j = 0; j < 17; j++) begin
      h1 = bits[16 - j] ? 2'b10 : 2'b01;
      h2 = bits[16 - j] ? 2'b01 : 2'b10;
      if (j == force_bit) begin
        h1 = 2'b11;
        h2 = 2'b11;
      end
      if (idle_after >= 0 && j > idle_after) begin
        h1 = 2'b00;
        h2 = 2'b00;
      end
      drive(h1, HB);
      drive(h2, HB);
    end
  endtask

  initial begin
    int   p;
    stb_t s;

    vecs[0] = '{1'b1, 16'hA5C3, 24, 1'b0, -1, -1, 8, 1'b1, 319, 16'hA5C3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 24, 1'b0, -1, -1, 0, 1'b1, 319, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'hFFFF, 24, 1'b0, -1, -1, 8, 1'b1, 319, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0001, 24, 1'b1, -1, -1, 8, 1'b1, 319, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h1234, 24, 1'b0,  7, 10, 8, 1'b1, 319, 16'h1320, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 16'hBEEF, 19, 1'b0, -1, -1, 8, 1'b0,   0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h5A5A, 20, 1'b0, -1, -1, 8, 1'b1, 315, 16'h5A5A, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h0F0F, 28, 1'b0, -1, -1, 8, 1'b1, 323, 16'h0F0F, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h3C3C, 29, 1'b0, -1, -1, 8, 1'b0,   0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'h8001, 24, 1'b0, -1, -1, 8, 1'b1, 319, 16'h8001, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    DI1   = 1'b0;
    DI0   = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy", busy_rcv, 0);
    check("rst_imp", imp_rcv, 0);
    check("rst_cd", cd_rcv, 0);
    check("rst_data", data_rcv, 0);
    check("rst_err_manch", err_manch, 0);
    check("rst_err_par", err_par, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_word(vecs[i].cmd, vecs[i].d, vecs[i].sync_len, vecs[i].inv_par,
                vecs[i].force_bit, vecs[i].idle_after, pv[i]);
      drive(2'b00, vecs[i].gap);
    end
    repeat (400) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_stb) begin
        if (sq.size() == 0) begin
          check($sformatf("v%0d_strobe_present", i), 0, 1);
        end else begin
          s = sq.pop_front();
          check($sformatf("v%0d_strobe_time", i), s.cyc, pv[i] + vecs[i].lat);
          check($sformatf("v%0d_data", i), s.data, vecs[i].exp_d);
          check($sformatf("v%0d_cd", i), s.cd, vecs[i].exp_cd);
          check($sformatf("v%0d_err_manch", i), s.em, vecs[i].exp_em);
          check($sformatf("v%0d_err_par", i), s.ep, vecs[i].exp_ep);
        end
      end
    end
    check("table_extra_strobes", sq.size(), 0);

    // Reset 100 clocks after the sync edge of a word in flight.
    fork
      begin
        send_word(1'b1, 16'h1357, 24, 1'b0, -1, -1, p);
      end
      begin
        int pr;
        @(negedge clk);
        pr = cyc + 1;
        while (cyc < pr + 26 + 99) @(negedge clk);
        check("mid_word_busy", busy_rcv, 1);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy_rcv, 0);
        check("midrst_imp", imp_rcv, 0);
        check("midrst_cd", cd_rcv, 0);
        check("midrst_data", data_rcv, 0);
        check("midrst_err_manch", err_manch, 0);
        check("midrst_err_par", err_par, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    drive(2'b00, 10);
    repeat (20) @(negedge clk);
    check("aborted_word_no_strobe", sq.size(), 0);

    send_word(1'b0, 16'h2468, 24, 1'b0, -1, -1, p);
    drive(2'b00, 8);
    repeat (330) @(negedge clk);
    if (sq.size() == 0) begin
      check("post_rst_strobe_present", 0, 1);
    end else begin
      s = sq.pop_front();
      check("post_rst_strobe_time", s.cyc, p + 319);
      check("post_rst_data", s.data, 16'h2468);
      check("post_rst_cd", s.cd, 0);
      check("post_rst_err_manch", s.em, 0);
      check("post_rst_err_par", s.ep, 0);
    end
    check("post_rst_extra_strobes", sq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
